muldiv_ctrl: RTL and testbench

//  Sequencer for the E-stage multiply/divide resource and owner of the HI/LO registers.

---
 rtl/md_pkg.sv | 30 +++
 rtl/md_arith.sv | 62 ++++++
 rtl/muldiv_ctrl.sv | 123 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// FSM state encoding and default execution latencies.
package md_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_MFX   = 3'd7
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam int unsigned MULT_LAT_DEF = 5;
   localparam int unsigned DIV_LAT_DEF  = 10;
   localparam int unsigned CNT_W_DEF    = 4;

   // True for ops that occupy the multi-cycle resource.
   function automatic logic md_is_arith(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: produces the HI/LO result for
// mult/multu/div/divu and flags a zero divisor for the divide ops.
module md_arith
   import md_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [31:0] hi_nx,
   output logic [31:0] lo_nx,
   output logic        div0
);

   logic               sgn;
   logic signed [63:0] sprod;
   logic        [63:0] uprod;
   logic               a_neg;
   logic               b_neg;
   logic        [31:0] ua;
   logic        [31:0] ub;
   logic        [31:0] ub_safe;
   logic        [31:0] q_mag;
   logic        [31:0] r_mag;
   logic        [31:0] quot;
   logic        [31:0] rem;

   assign sgn   = (op == MD_MULT) || (op == MD_DIV);
   assign sprod = $signed(rs_val) * $signed(rt_val);
   assign uprod = {32'd0, rs_val} * {32'd0, rt_val};

   // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000
   // with a zero remainder instead of depending on overflow semantics.
   always_comb begin
      a_neg   = sgn & rs_val[31];
      b_neg   = sgn & rt_val[31];
      ua      = a_neg ? (32'd0 - rs_val) : rs_val;
      ub      = b_neg ? (32'd0 - rt_val) : rt_val;
      ub_safe = (ub == '0) ? 32'd1 : ub;
      q_mag   = ua / ub_safe;
      r_mag   = ua % ub_safe;
      quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem     = a_neg ? (32'd0 - r_mag) : r_mag;
   end

   // Select the result pair for the requested op.
   always_comb begin
      hi_nx = '0;
      lo_nx = '0;
      div0  = 1'b0;
      case (op)
         MD_MULT:  {hi_nx, lo_nx} = sprod;
         MD_MULTU: {hi_nx, lo_nx} = uprod;
         MD_DIV, MD_DIVU: begin
            hi_nx = rem;
            lo_nx = quot;
            div0  = (rt_val == '0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer and HI/LO owner. Models fixed-latency execution
// and drives the start/busy pair used by the stall unit.
// Optional feature: define MD_CANCEL_EN to add the cancel (E-stage flush) port.
module muldiv_ctrl
   import md_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        md_valid,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
`ifdef MD_CANCEL_EN
   ,
   input  logic        cancel
`endif
);

   md_state_e        state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [31:0]      pend_hi, pend_hi_nx;
   logic [31:0]      pend_lo, pend_lo_nx;
   logic             pend_div0, pend_div0_nx;
   logic [31:0]      hi_d, lo_d;
   logic [31:0]      ar_hi, ar_lo;
   logic             ar_div0;
   logic             kill;
   logic             accept;

`ifdef MD_CANCEL_EN
   assign kill = cancel;
`else
   assign kill = 1'b0;
`endif

   assign accept = md_valid && (state == ST_IDLE) && !kill;
   assign start  = accept && md_is_arith(md_op);
   assign busy   = (cnt != '0);

   md_arith u_arith (
      .op     (md_op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .hi_nx  (ar_hi),
      .lo_nx  (ar_lo),
      .div0   (ar_div0)
   );

   // Next-state, countdown, pending-result and HI/LO update logic.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      pend_hi_nx   = pend_hi;
      pend_lo_nx   = pend_lo;
      pend_div0_nx = pend_div0;
      hi_d         = hi;
      lo_d         = lo;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nx     = ST_RUN;
               cnt_nx       = ((md_op == MD_DIV) || (md_op == MD_DIVU)) ?
                              CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
               pend_hi_nx   = ar_hi;
               pend_lo_nx   = ar_lo;
               pend_div0_nx = ar_div0;
            end else if (accept && (md_op == MD_MTHI)) begin
               hi_d = rs_val;
            end else if (accept && (md_op == MD_MTLO)) begin
               lo_d = rs_val;
            end
         end
         ST_RUN: begin
            if (cnt == CNT_W'(1)) begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
               if (!pend_div0) begin
                  hi_d = pend_hi;
                  lo_d = pend_lo;
               end
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // State, countdown, pending results and architectural HI/LO registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         pend_hi   <= '0;
         pend_lo   <= '0;
         pend_div0 <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         pend_hi   <= pend_hi_nx;
         pend_lo   <= pend_lo_nx;
         pend_div0 <= pend_div0_nx;
         hi        <= hi_d;
         lo        <= lo_d;
      end
   end

   // The stall unit must never present a muldiv-class op while running.
   a_no_issue_in_run: assert property (@(posedge clk) disable iff (!reset)
                                       !(md_valid && (state == ST_RUN)))
      else $error("muldiv_ctrl: md_valid asserted while RUN");

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: driver pushes expected HI/LO and busy
// length from a plain-arithmetic reference model; monitor pops and compares.
module tb_muldiv_ctrl;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        md_valid = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
`ifdef MD_CANCEL_EN
   logic        cancel = 1'b0;
`endif

   always #5 clk = ~clk;

   muldiv_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .md_valid (md_valid),
      .md_op    (md_op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .start    (start),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo)
`ifdef MD_CANCEL_EN
      ,
      .cancel   (cancel)
`endif
   );

   typedef struct {
      bit          is_md;
      logic [31:0] hi;
      logic [31:0] lo;
      int unsigned lat;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   int          n_pass = 0;
   int          n_tot = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference results straight from the architectural definitions.
   function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     inout logic [31:0] h, inout logic [31:0] l,
                                     output int unsigned lat);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      lat = 0;
      case (op)
         MD_MULT:  begin q = sa * sb; h = q[63:32]; l = q[31:0]; lat = 5; end
         MD_MULTU: begin p = ua * ub; h = p[63:32]; l = p[31:0]; lat = 5; end
         MD_DIV: begin
            lat = 10;
            if (b != 0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
         end
         MD_DIVU: begin
            lat = 10;
            if (b != 0) begin p = ua / ub; l = p[31:0]; p = ua % ub; h = p[31:0]; end
         end
         MD_MTHI: h = a;
         MD_MTLO: l = a;
         default: ;
      endcase
   endfunction

   task automatic wait_idle();
      int unsigned n = 0;
      while ((busy || sb_q.size() != 0) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 40) begin
         check("idle_timeout", 64'd1, 64'd0);
         sb_q.delete();
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the acceptance edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit cx, input bit wait_done);
      logic [31:0] nh, nl;
      int unsigned lat;
      bit          arith;
      exp_t        e;
      arith = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
      md_valid = 1'b1;
      md_op    = op;
      rs_val   = a;
      rt_val   = b;
`ifdef MD_CANCEL_EN
      cancel   = cx;
`endif
      #1;
      check("start", {63'd0, start}, {63'd0, arith && !cx});
      nh = m_hi;
      nl = m_lo;
      ref_model(op, a, b, nh, nl, lat);
      if (arith && !cx) begin
         e.is_md = 1'b1; e.hi = nh; e.lo = nl; e.lat = lat;
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      md_valid = 1'b0;
      md_op    = MD_NONE;
`ifdef MD_CANCEL_EN
      cancel   = 1'b0;
`endif
      if (!cx) begin
         m_hi = nh;
         m_lo = nl;
      end
      if ((op == MD_MTHI) || (op == MD_MTLO)) begin
         e.is_md = 1'b0; e.hi = m_hi; e.lo = m_lo; e.lat = 0;
         sb_q.push_back(e);
      end
      if (arith && cx) check("busy_after_cancel", {63'd0, busy}, 64'd0);
      if (arith && !cx && wait_done) wait_idle();
   endtask

   // Monitor: a busy falling edge retires an arithmetic op; a queued
   // mthi/mtlo entry is checked the cycle after its write edge.
   initial begin
      int unsigned busy_cnt = 0;
      logic        busy_prev = 1'b0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            busy_prev = 1'b0;
            busy_cnt  = 0;
         end else begin
            if (busy) begin
               busy_cnt++;
            end else if (busy_prev) begin
               if (sb_q.size() == 0 || !sb_q[0].is_md) begin
                  check("unexpected_completion", 64'd1, 64'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("busy_len", 64'(busy_cnt), 64'(e.lat));
                  check("md_hi", {32'd0, hi}, {32'd0, e.hi});
                  check("md_lo", {32'd0, lo}, {32'd0, e.lo});
               end
               busy_cnt = 0;
            end else if (sb_q.size() != 0 && !sb_q[0].is_md) begin
               e = sb_q.pop_front();
               check("mt_hi", {32'd0, hi}, {32'd0, e.hi});
               check("mt_lo", {32'd0, lo}, {32'd0, e.lo});
               check("mt_busy", {63'd0, busy}, 64'd0);
            end
            busy_prev = busy;
         end
      end
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int unsigned sel;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      reset = 1'b1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      @(posedge clk); #1;

      // Product and quotient examples
      issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
      check("mult_m2x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      issue(MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b1);
      check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
      check("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
      check("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});

      // Divide by zero leaves HI/LO alone
      issue(MD_MTHI, 32'h11, 32'd0, 1'b0, 1'b0);
      issue(MD_MTLO, 32'h22, 32'd0, 1'b0, 1'b0);
      issue(MD_DIV, 32'd5, 32'd0, 1'b0, 1'b1);
      check("div0_keep", {hi, lo}, {32'h11, 32'h22});

      // Back-to-back moves
      issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
      issue(MD_MTLO, 32'h1234, 32'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("mt_pair", {hi, lo}, {32'hDEAD_BEEF, 32'h1234});

      // Reset in the third RUN cycle of a divide
      issue(MD_DIV, 32'd1000, 32'd3, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_hilo", {hi, lo}, 64'd0);
      sb_q.delete();
      m_hi = '0;
      m_lo = '0;
      @(negedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("post_abort_hilo", {hi, lo}, 64'd0);

`ifdef MD_CANCEL_EN
      issue(MD_MULT, 32'd6, 32'd7, 1'b1, 1'b0);
      @(posedge clk); #1;
      check("cancel_no_busy", {63'd0, busy}, 64'd0);
      issue(MD_MTHI, 32'h5555, 32'd0, 1'b1, 1'b0);
      issue(MD_MULT, 32'd6, 32'd7, 1'b0, 1'b0);
      @(posedge clk); #1;
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      wait_idle();
      check("cancel_run_commit", {hi, lo}, {32'd0, 32'd42});
`endif

      // Randomized ops with corner-biased operands
      for (int i = 0; i < 60; i++) begin
         op  = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 7);
         a   = $urandom;
         b   = $urandom;
         if (sel == 0) b = '0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) b = 32'($urandom_range(1, 9));
         issue(op, a, b, 1'b0, 1'b1);
      end

      wait_idle();
      @(posedge clk); #1;
      check("final_hilo", {hi, lo}, {m_hi, m_lo});
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
